// File: rtl/float_divider_seq.sv
// Sequential IEEE-754 single-precision divider (restoring radix-2, one quotient bit per cycle).
// Denormal inputs are flushed to zero and no denormal results are produced.
// Optional build macro: FDIV_ROUND_EN selects round-to-nearest-even; the default build truncates.
// Both builds have the same latency.
module float_divider_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  localparam int unsigned QW = 26;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_ITER = CW'(QW - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] DIVIDE = 3'd2;
  localparam logic [2:0] NORM   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]        state, next_state;
  logic [31:0]       a_q, b_q;
  logic [23:0]       nb;
  logic [24:0]       rem;
  logic [QW-1:0]     q;
  logic [CW-1:0]     cnt;
  logic signed [9:0] exp_q;
  logic [31:0]       res_q;
  logic              ovf_q, unf_q, exc_q;

  logic              sign_c;
  logic              special_c, spec_exc_c;
  logic [31:0]       spec_res_c;
  logic signed [9:0] exp_c;
  logic              ge_c;
  logic [23:0]       rem_sub_c;
  logic signed [9:0] e_n_c, e_r_c;
  logic [22:0]       frac_c, frac_r_c;
  logic              ovf_c, unf_c;
  logic [31:0]       norm_res_c;
`ifdef FDIV_ROUND_EN
  logic              guard_c, sticky_c, up_c;
  logic [24:0]       sum_c;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; a start coinciding with the done pulse is not accepted
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && !done) next_state = CHECK;
      CHECK:   next_state = special_c ? DONE : DIVIDE;
      DIVIDE:  if (cnt == LAST_ITER) next_state = NORM;
      NORM:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand classification and biased exponent difference
  always_comb begin
    sign_c     = a_q[31] ^ b_q[31];
    special_c  = 1'b1;
    spec_exc_c = 1'b0;
    spec_res_c = '0;
    exp_c      = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
    if (a_q[30:23] == 8'hFF || b_q[30:23] == 8'hFF) begin
      spec_res_c = QNAN;
      spec_exc_c = 1'b1;
    end else if (b_q[30:23] == 8'h00 && a_q[30:23] == 8'h00) begin
      spec_res_c = QNAN;
      spec_exc_c = 1'b1;
    end else if (b_q[30:23] == 8'h00) begin
      spec_res_c = {sign_c, 8'hFF, 23'd0};
      spec_exc_c = 1'b1;
    end else if (a_q[30:23] == 8'h00) begin
      spec_res_c = {sign_c, 31'd0};
    end else begin
      special_c = 1'b0;
    end
  end

  // One restoring divide step; the remainder always stays below the divisor
  always_comb begin
    ge_c      = rem >= {1'b0, nb};
    rem_sub_c = ge_c ? 24'(rem - {1'b0, nb}) : rem[23:0];
  end

  // Normalisation, optional rounding and range check
  always_comb begin
    e_n_c  = q[25] ? exp_q : exp_q - 10'sd1;
    frac_c = q[25] ? q[24:2] : q[23:1];
`ifdef FDIV_ROUND_EN
    guard_c  = q[25] ? q[1] : q[0];
    sticky_c = (q[25] & q[0]) | (|rem);
    up_c     = guard_c & (sticky_c | frac_c[0]);
    sum_c    = {2'b01, frac_c} + 25'(up_c);
    // on carry-out the sum is exactly 2.0, so the low fraction bits are already zero
    frac_r_c = sum_c[22:0];
    e_r_c    = sum_c[24] ? e_n_c + 10'sd1 : e_n_c;
`else
    frac_r_c = frac_c;
    e_r_c    = e_n_c;
`endif
    ovf_c = e_r_c >= 10'sd255;
    unf_c = !ovf_c && (e_r_c <= 10'sd0);
    if (ovf_c)      norm_res_c = {sign_c, 8'hFF, 23'd0};
    else if (unf_c) norm_res_c = {sign_c, 31'd0};
    else            norm_res_c = {sign_c, e_r_c[7:0], frac_r_c};
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      nb        <= '0;
      rem       <= '0;
      q         <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start && !done) begin
            a_q <= A[31:0];
            b_q <= B[31:0];
          end
        end
        CHECK: begin
          exp_q <= exp_c;
          rem   <= {2'b01, a_q[22:0]};
          nb    <= {1'b1, b_q[22:0]};
          q     <= '0;
          cnt   <= '0;
          res_q <= spec_res_c;
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
          exc_q <= spec_exc_c;
        end
        DIVIDE: begin
          rem <= {rem_sub_c, 1'b0};
          q   <= {q[QW-2:0], ge_c};
          cnt <= cnt + CW'(1);
        end
        NORM: begin
          res_q <= norm_res_c;
          ovf_q <= ovf_c;
          unf_q <= unf_c;
          exc_q <= 1'b0;
        end
        DONE: begin
          result    <= XLEN'(res_q);
          overflow  <= ovf_q;
          underflow <= unf_q;
          exception <= exc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_divider_seq.sv
// Scoreboard bench for float_divider_seq: directed vectors with hand-computed quotients.
module tb_float_divider_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b, result;
  logic        busy, done, overflow, underflow, exception;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [2:0]  flags;  // {overflow, underflow, exception}
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

`ifdef FDIV_ROUND_EN
  localparam logic [31:0] EXP_1_3 = 32'h3EAA_AAAB;
`else
  localparam logic [31:0] EXP_1_3 = 32'h3EAA_AAAA;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  float_divider_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow), .exception(exception)
  );

  // Monitor: every done pulse is matched against the oldest expected response
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got result=%h at cycle %0d, required no done", result, cyc);
      end else begin
        e = sb.pop_front();
        n_tests++;
        if ({result, overflow, underflow, exception} !== {e.res, e.flags}) begin
          n_fail++;
          $display("FAIL %s: got result=%h ovf/unf/exc=%b, required result=%h ovf/unf/exc=%b",
                   e.name, result, {overflow, underflow, exception}, e.res, e.flags);
        end
        n_tests++;
        if (cyc - e.acc != e.lat) begin
          n_fail++;
          $display("FAIL %s_latency: got %0d cycles, required %0d", e.name, cyc - e.acc, e.lat);
        end
      end
    end
  end

  function automatic void push(string nm, logic [31:0] r, logic [2:0] f, int lat, int acc);
    exp_t x;
    x.name = nm; x.res = r; x.flags = f; x.lat = lat; x.acc = acc;
    sb.push_back(x);
  endfunction

  task automatic wait_done(string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within 60 cycles, required done", nm);
    end
  endtask

  task automatic run(string nm, logic [31:0] av, logic [31:0] bv,
                     logic [31:0] r, logic [2:0] f, int lat);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    push(nm, r, f, lat, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(nm);
  endtask

  task automatic check_idle(string nm);
    n_tests++;
    if ({busy, done, result, overflow, underflow, exception} !== 36'd0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b result=%h flags=%b, required all zero",
               nm, busy, done, result, {overflow, underflow, exception});
    end
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    run("6_div_2",     32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29);
    run("1_div_3",     32'h3F800000, 32'h40400000, EXP_1_3,      3'b000, 29);
    run("1_div_0",     32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 2);
    run("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 29);
    run("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 29);
    run("nan_in",      32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001, 2);
    run("0_div_0",     32'h00000000, 32'h00000000, 32'h7FC00000, 3'b001, 2);
    run("inf_div_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b001, 2);
    run("negz_div_2",  32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 2);
    run("denorm_a",    32'h00000001, 32'h40000000, 32'h00000000, 3'b000, 2);
    run("neg1_denorm", 32'hBF800000, 32'h00000001, 32'hFF800000, 3'b001, 2);
    run("neg6_div_2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 29);
    run("3_div_2",     32'h40400000, 32'h40000000, 32'h3FC00000, 3'b000, 29);
    run("1_div_1",     32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 29);

    // start while busy is ignored
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    push("busy_ignore", 32'h40400000, 3'b000, 29, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_high: got busy=%b, required 1", busy);
    end
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ignore");

    // start held through the done cycle is taken one cycle later
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    push("pre_done", 32'h40400000, 3'b000, 29, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wait_done("pre_done");
    a = 32'h3F800000; b = 32'h3F800000; start = 1'b1;
    push("start_on_done", 32'h3F800000, 3'b000, 29, cyc + 2);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("start_on_done");

    // reset mid-divide aborts without a done pulse
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_abort");
    repeat (35) @(negedge clk);
    check_idle("rst_quiet");
    run("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29);

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending: got %0d outstanding results, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
